// File: rtl/mem_port_arb.sv
// mem_port_arb: two-requester (fetch/data) arbiter for one single-port memory, one transaction in flight.
// Optional MEM_ARB_PERF_EN adds 32-bit stall-cycle counters for both requesters.
module mem_port_arb #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    input  logic                i_if_flush,
    output logic [DATA_W-1:0]   o_if_rdata,
    output logic                o_if_vld,
    output logic                o_if_hold,
    input  logic                i_d_req,
    input  logic                i_d_wen,
    input  logic [ADDR_W-1:0]   i_d_addr,
    input  logic [DATA_W-1:0]   i_d_wdata,
    input  logic [DATA_W/8-1:0] i_d_mask,
    output logic [DATA_W-1:0]   o_d_rdata,
    output logic                o_d_vld,
    output logic                o_d_busy,
    output logic                o_mem_req,
    output logic                o_mem_wen,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_mask,
    input  logic                i_mem_ready,
    input  logic                i_mem_rvld,
    input  logic [DATA_W-1:0]   i_mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]         o_if_stall_cnt,
    output logic [31:0]         o_d_stall_cnt
`endif
);
    typedef enum logic [2:0] {IDLE, REQ_IF, REQ_D, WAIT_IF, WAIT_D} state_t;
    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
    state_t     state;
    logic [3:0] starve_cnt;
    logic       drop;
    logic       grant_if, grant_d, req_st, wait_st, in_if, done, drop_now;
    assign grant_if  = state == IDLE && i_if_req && (!i_d_req || starve_cnt == LIM);
    assign grant_d   = state == IDLE && i_d_req && !grant_if;
    assign req_st    = state == REQ_IF || state == REQ_D;
    assign wait_st   = state == WAIT_IF || state == WAIT_D;
    assign in_if     = state == REQ_IF || state == WAIT_IF;
    assign done      = i_mem_rvld && (wait_st || (req_st && i_mem_ready));
    // a flush arriving in the same cycle as the response must still drop it
    assign drop_now  = drop || (i_if_flush && in_if);
    assign o_mem_req = req_st;
    assign o_if_hold = i_if_req && !o_if_vld;
    assign o_d_busy  = i_d_req && !o_d_vld;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            drop        <= 1'b0;
            o_if_vld    <= 1'b0;
            o_d_vld     <= 1'b0;
            o_if_rdata  <= '0;
            o_d_rdata   <= '0;
            o_mem_wen   <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_mask  <= '0;
        end else begin
            o_if_vld <= 1'b0;
            o_d_vld  <= 1'b0;
            if (!i_if_req || grant_if)
                starve_cnt <= '0;
            else if (grant_d && starve_cnt != LIM)
                starve_cnt <= starve_cnt + 4'd1;
            case (state)
                IDLE: begin
                    if (grant_if) begin
                        state       <= REQ_IF;
                        o_mem_wen   <= 1'b0;
                        o_mem_addr  <= i_if_addr;
                        o_mem_wdata <= '0;
                        o_mem_mask  <= '1;
                    end else if (grant_d) begin
                        state       <= REQ_D;
                        o_mem_wen   <= i_d_wen;
                        o_mem_addr  <= i_d_addr;
                        o_mem_wdata <= i_d_wdata;
                        o_mem_mask  <= i_d_mask;
                    end
                end
                REQ_IF, REQ_D: begin
                    if (i_mem_ready)
                        state <= i_mem_rvld ? IDLE : (in_if ? WAIT_IF : WAIT_D);
                end
                WAIT_IF, WAIT_D: begin
                    if (i_mem_rvld)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (i_if_flush && in_if)
                drop <= 1'b1;
            if (done && in_if) begin
                drop <= 1'b0;
                if (!drop_now) begin
                    o_if_vld   <= 1'b1;
                    o_if_rdata <= i_mem_rdata;
                end
            end else if (done) begin
                o_d_vld   <= 1'b1;
                o_d_rdata <= i_mem_rdata;
            end
        end
    end
`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_if_stall_cnt <= '0;
            o_d_stall_cnt  <= '0;
        end else begin
            o_if_stall_cnt <= o_if_stall_cnt + 32'(o_if_hold);
            o_d_stall_cnt  <= o_d_stall_cnt + 32'(o_d_busy);
        end
    end
`endif
endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: directed table plus corner-case sequences for mem_port_arb against a small memory responder.
module tb_mem_port_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_if_req = 1'b0, i_if_flush = 1'b0;
    logic [31:0] i_if_addr = '0;
    logic [31:0] o_if_rdata, o_d_rdata, o_mem_addr, o_mem_wdata;
    logic        o_if_vld, o_if_hold, o_d_vld, o_d_busy, o_mem_req, o_mem_wen;
    logic        i_d_req = 1'b0, i_d_wen = 1'b0;
    logic [31:0] i_d_addr = '0, i_d_wdata = '0;
    logic [3:0]  i_d_mask = '0, o_mem_mask;
    logic        i_mem_ready = 1'b0, i_mem_rvld = 1'b0;
    logic [31:0] i_mem_rdata = '0;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] if_stall_cnt, d_stall_cnt;
`endif

    mem_port_arb dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_flush(i_if_flush),
        .o_if_rdata(o_if_rdata), .o_if_vld(o_if_vld), .o_if_hold(o_if_hold),
        .i_d_req(i_d_req), .i_d_wen(i_d_wen), .i_d_addr(i_d_addr),
        .i_d_wdata(i_d_wdata), .i_d_mask(i_d_mask),
        .o_d_rdata(o_d_rdata), .o_d_vld(o_d_vld), .o_d_busy(o_d_busy),
        .o_mem_req(o_mem_req), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
        .i_mem_ready(i_mem_ready), .i_mem_rvld(i_mem_rvld), .i_mem_rdata(i_mem_rdata)
`ifdef MEM_ARB_PERF_EN
        , .o_if_stall_cnt(if_stall_cnt), .o_d_stall_cnt(d_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int stall_left = 0;
    logic pend = 1'b0, hold_resp = 1'b0;
    logic [31:0] resp = '0;
    logic [31:0] log_addr[$], log_wdata[$];
    logic        log_wen[$];
    logic [3:0]  log_mask[$];

    typedef struct {
        logic        fetch;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;
    vec_t tbl[5];

    function automatic logic [31:0] word(input logic [31:0] a);
        case (a)
            32'h100: return 32'h0000_0033;
            32'h200: return 32'hDEAD_BEEF;
            32'h300: return 32'h1111_2222;
            default: return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_wdata.delete();
        log_wen.delete();
        log_mask.delete();
    endtask

    // responder: ready after stall_left REQ cycles, response one cycle after acceptance
    initial forever begin
        @(negedge clk);
        i_mem_rvld = 1'b0;
        if (pend && !hold_resp) begin
            i_mem_rvld  = 1'b1;
            i_mem_rdata = resp;
            pend        = 1'b0;
        end
        i_mem_ready = 1'b0;
        if (o_mem_req) begin
            if (stall_left > 0) begin
                stall_left--;
            end else begin
                i_mem_ready = 1'b1;
                log_addr.push_back(o_mem_addr);
                log_wdata.push_back(o_mem_wdata);
                log_wen.push_back(o_mem_wen);
                log_mask.push_back(o_mem_mask);
                resp = word(o_mem_addr);
                pend = 1'b1;
            end
        end
    end

    task automatic txn(input vec_t v, output logic [31:0] rd, output int lat);
        rd  = '0;
        lat = -1;
        if (v.fetch) begin
            i_if_req  = 1'b1;
            i_if_addr = v.addr;
        end else begin
            i_d_req   = 1'b1;
            i_d_wen   = v.wen;
            i_d_addr  = v.addr;
            i_d_wdata = v.wdata;
            i_d_mask  = v.mask;
        end
        #1;
        chk("stall_at_req", 32'(v.fetch ? o_if_hold : o_d_busy), 32'd1);
        for (int c = 1; c <= 30; c++) begin
            step();
            if (v.fetch ? o_if_vld : o_d_vld) begin
                lat = c;
                rd  = v.fetch ? o_if_rdata : o_d_rdata;
                break;
            end
        end
        chk("stall_at_vld", 32'(v.fetch ? o_if_hold : o_d_busy), 32'd0);
        i_if_req = 1'b0;
        i_d_req  = 1'b0;
    endtask

    logic [31:0] rd, frd, e;
    int lat, d_at, f_at, k, n, f_done;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 32'h100,  32'h0,         4'hF, 32'h0000_0033, 3};
        tbl[1] = '{1'b0, 1'b0, 32'h2000, 32'h0,         4'hF, 32'h5A5A_2000, 3};
        tbl[2] = '{1'b0, 1'b1, 32'h2004, 32'hCAFE_F00D, 4'hF, 32'h0,         3};
        tbl[3] = '{1'b1, 1'b0, 32'h300,  32'h0,         4'hF, 32'h1111_2222, 3};
        tbl[4] = '{1'b0, 1'b0, 32'h2008, 32'h0,         4'h1, 32'h5A5A_2008, 3};

        i_if_req = 1'b1;
        i_d_req  = 1'b1;
        #2;
        chk("rst_mem_req", 32'(o_mem_req), 32'd0);
        chk("rst_mem_wen", 32'(o_mem_wen), 32'd0);
        chk("rst_mem_addr", o_mem_addr, 32'd0);
        chk("rst_mem_wdata", o_mem_wdata, 32'd0);
        chk("rst_mem_mask", 32'(o_mem_mask), 32'd0);
        chk("rst_if_vld", 32'(o_if_vld), 32'd0);
        chk("rst_d_vld", 32'(o_d_vld), 32'd0);
        chk("rst_if_rdata", o_if_rdata, 32'd0);
        chk("rst_d_rdata", o_d_rdata, 32'd0);
        chk("rst_if_hold", 32'(o_if_hold), 32'd1);
        chk("rst_d_busy", 32'(o_d_busy), 32'd1);
        i_if_req = 1'b0;
        i_d_req  = 1'b0;
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            clear_log();
            txn(tbl[i], rd, lat);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
            if (!tbl[i].wen)
                chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("vec%0d_nlog", i), 32'(log_addr.size()), 32'd1);
            if (log_addr.size() > 0) begin
                chk($sformatf("vec%0d_addr", i), log_addr[0], tbl[i].addr);
                chk($sformatf("vec%0d_wen", i), 32'(log_wen[0]), 32'(tbl[i].wen));
                if (!tbl[i].fetch)
                    chk($sformatf("vec%0d_mask", i), 32'(log_mask[0]), 32'(tbl[i].mask));
                if (tbl[i].wen)
                    chk($sformatf("vec%0d_wdata", i), log_wdata[0], tbl[i].wdata);
            end
            step();
        end

        clear_log();
        i_if_req = 1'b1; i_if_addr = 32'h104;
        i_d_req = 1'b1; i_d_wen = 1'b0; i_d_addr = 32'h2000; i_d_mask = 4'hF;
        d_at = -1; f_at = -1; frd = '0;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (o_d_vld && d_at < 0) begin d_at = c; i_d_req = 1'b0; end
            if (o_if_vld && f_at < 0) begin f_at = c; frd = o_if_rdata; i_if_req = 1'b0; end
            if (d_at >= 0 && f_at >= 0) break;
        end
        chk("simul_d_at", 32'(d_at), 32'd3);
        chk("simul_if_at", 32'(f_at), 32'd6);
        chk("simul_if_rdata", frd, 32'h5A5A_0104);
        chk("simul_nlog", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() == 2) begin
            chk("simul_first", log_addr[0], 32'h2000);
            chk("simul_second", log_addr[1], 32'h104);
        end
        step();

        clear_log();
        k = 0; f_done = 0;
        i_if_req = 1'b1; i_if_addr = 32'h500;
        i_d_req = 1'b1; i_d_wen = 1'b0; i_d_addr = 32'h4000;
        for (int c = 1; c <= 200; c++) begin
            step();
            if (o_d_vld) begin
                k++;
                if (k == 10) i_d_req = 1'b0;
                else i_d_addr = 32'h4000 + 32'(4 * k);
            end
            if (o_if_vld) begin
                i_if_req = 1'b0;
                f_done = 1;
            end
            if (k == 10 && f_done == 1) break;
        end
        chk("starve_loads", 32'(k), 32'd10);
        chk("starve_fetch", 32'(f_done), 32'd1);
        chk("starve_nlog", 32'(log_addr.size()), 32'd11);
        for (int j = 0; j < 11 && j < log_addr.size(); j++) begin
            e = j < 4 ? 32'h4000 + 32'(4 * j) : (j == 4 ? 32'h500 : 32'h4000 + 32'(4 * (j - 1)));
            chk($sformatf("starve_grant%0d", j), log_addr[j], e);
        end
        step();

        for (int fc = 1; fc <= 2; fc++) begin
            clear_log();
            n = 0; f_at = -1; frd = '0;
            i_if_req = 1'b1; i_if_addr = 32'h200;
            for (int c = 1; c <= 20; c++) begin
                step();
                if (o_if_vld) begin
                    n++;
                    if (f_at < 0) begin f_at = c; frd = o_if_rdata; end
                    i_if_req = 1'b0;
                end
                if (c == fc) begin i_if_flush = 1'b1; i_if_addr = 32'h300; end
                if (c == fc + 1) i_if_flush = 1'b0;
            end
            chk($sformatf("flush%0d_pulses", fc), 32'(n), 32'd1);
            chk($sformatf("flush%0d_at", fc), 32'(f_at), 32'd6);
            chk($sformatf("flush%0d_rdata", fc), frd, 32'h1111_2222);
            chk($sformatf("flush%0d_nlog", fc), 32'(log_addr.size()), 32'd2);
            if (log_addr.size() == 2)
                chk($sformatf("flush%0d_first", fc), log_addr[0], 32'h200);
        end

        clear_log();
        stall_left = 3;
        n = 0; d_at = -1;
        i_d_req = 1'b1; i_d_wen = 1'b1; i_d_addr = 32'h3000;
        i_d_wdata = 32'h1234_5678; i_d_mask = 4'b0011;
        for (int c = 1; c <= 15; c++) begin
            step();
            if (c <= 4) begin
                chk($sformatf("bp%0d_req", c), 32'(o_mem_req), 32'd1);
                chk($sformatf("bp%0d_addr", c), o_mem_addr, 32'h3000);
                chk($sformatf("bp%0d_wdata", c), o_mem_wdata, 32'h1234_5678);
                chk($sformatf("bp%0d_mask", c), 32'(o_mem_mask), 32'h3);
                chk($sformatf("bp%0d_wen", c), 32'(o_mem_wen), 32'd1);
                chk($sformatf("bp%0d_busy", c), 32'(o_d_busy), 32'd1);
            end
            if (o_d_vld) begin
                n++;
                if (d_at < 0) d_at = c;
                i_d_req = 1'b0;
            end
        end
        chk("bp_pulses", 32'(n), 32'd1);
        chk("bp_vld_at", 32'(d_at), 32'd6);

        hold_resp = 1'b1;
        i_d_req = 1'b1; i_d_wen = 1'b0; i_d_addr = 32'h2010; i_d_mask = 4'hF;
        step();
        step();
        chk("wd_addr", o_mem_addr, 32'h2010);
        #3;
        rst = 1'b1;
        i_d_req = 1'b0;
        #1;
        chk("arst_mem_req", 32'(o_mem_req), 32'd0);
        chk("arst_d_vld", 32'(o_d_vld), 32'd0);
        chk("arst_mem_addr", o_mem_addr, 32'd0);
        chk("arst_d_rdata", o_d_rdata, 32'd0);
`ifdef MEM_ARB_PERF_EN
        chk("arst_if_cnt", if_stall_cnt, 32'd0);
        chk("arst_d_cnt", d_stall_cnt, 32'd0);
`endif
        step();
        rst = 1'b0;
        pend = 1'b0;
        hold_resp = 1'b0;
        clear_log();
        txn(tbl[0], rd, lat);
        chk("post_rst_lat", 32'(lat), 32'd3);
        chk("post_rst_rdata", rd, 32'h0000_0033);
`ifdef MEM_ARB_PERF_EN
        chk("perf_if_cnt", if_stall_cnt, 32'd3);
        chk("perf_d_cnt", d_stall_cnt, 32'd0);
`endif
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
